// File: rtl/intr_stim_pkg.sv
// intr_stim_pkg: shared types for the interrupt stimulus generator.
// Config fields are sized for the widest supported counters.
package intr_stim_pkg;

  localparam int unsigned CW_MAX = 32;
  localparam int unsigned RW_MAX = 16;
  localparam int unsigned JW     = 4;

  typedef enum logic {
    PULSE = 1'b0,
    LEVEL = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    ASSERT,
    WAIT_ACK,
    GAP
  } ch_state_e;

  typedef struct packed {
    mode_e             mode;
    logic [CW_MAX-1:0] dly;
    logic [CW_MAX-1:0] wid;
    logic [CW_MAX-1:0] gap;
    logic [RW_MAX-1:0] cnt;
  } ch_cfg_t;

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/intr_stim_if.sv
// intr_stim_if: channel configuration write bus.
// The master drives a write; the slave answers with a reject pulse.
interface intr_stim_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CW     = 16,
  parameter int unsigned RW     = 8
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic           cfg_we_i;
  logic [CHW-1:0] cfg_ch_i;
  logic           cfg_mode_i;
  logic [CW-1:0]  cfg_dly_i;
  logic [CW-1:0]  cfg_wid_i;
  logic [CW-1:0]  cfg_gap_i;
  logic [RW-1:0]  cfg_cnt_i;
  logic           cfg_err_o;

  modport master (
    output cfg_we_i,
    output cfg_ch_i,
    output cfg_mode_i,
    output cfg_dly_i,
    output cfg_wid_i,
    output cfg_gap_i,
    output cfg_cnt_i,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_we_i,
    input  cfg_ch_i,
    input  cfg_mode_i,
    input  cfg_dly_i,
    input  cfg_wid_i,
    input  cfg_gap_i,
    input  cfg_cnt_i,
    output cfg_err_o
  );

endinterface

// File: rtl/intr_stim_chan.sv
// intr_stim_chan: one interrupt channel sequencer.
// Walks delay, assertion, optional ack wait and gap phases.
module intr_stim_chan
  import intr_stim_pkg::*;
#(
  parameter int unsigned CW = 16,
  parameter int unsigned RW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  ch_cfg_t       cfg_i,
  input  logic [JW-1:0] jit_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          ack_i,
  output logic          intr_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned TW = CW + 1;

  ch_state_e     state_q;
  logic [TW-1:0] tmr_q;
  logic [RW-1:0] rep_q;
  logic          intr_q;
  logic          done_q;

  logic [CW-1:0] dly;
  logic [CW-1:0] wid;
  logic [CW-1:0] gap;
  logic [RW-1:0] cnt;
  logic          lvl;
  logic [TW-1:0] wid_ld;
  logic [TW-1:0] gap_len;
  logic          fin;

  ch_state_e     end_state_d;
  logic [TW-1:0] end_tmr_d;
  logic [RW-1:0] end_rep_d;
  logic          end_intr_d;
  logic          end_done_d;

  assign dly = cfg_i.dly[CW-1:0];
  assign wid = cfg_i.wid[CW-1:0];
  assign gap = cfg_i.gap[CW-1:0];
  assign cnt = cfg_i.cnt[RW-1:0];
  assign lvl = (cfg_i.mode == LEVEL);

  if (CW < CW_MAX) begin : g_cw_hi
    logic unused_cw_hi;
    assign unused_cw_hi = ^{cfg_i.dly[CW_MAX-1:CW],
                            cfg_i.wid[CW_MAX-1:CW],
                            cfg_i.gap[CW_MAX-1:CW]};
  end

  if (RW < RW_MAX) begin : g_rw_hi
    logic unused_rw_hi;
    assign unused_rw_hi = ^cfg_i.cnt[RW_MAX-1:RW];
  end

  // Width 0 behaves as 1; timer holds cycles left minus one.
  assign wid_ld  = (wid == '0) ? '0 : TW'(wid) - TW'(1);
  assign gap_len = TW'(gap) + TW'(jit_i);

  // An assertion ends on its width timer or on acknowledge.
  assign fin = ((state_q == ASSERT) &&
                (lvl ? ack_i : (tmr_q == '0))) ||
               ((state_q == WAIT_ACK) && ack_i);

  // Next phase once an assertion ends; last one skips the gap.
  always_comb begin
    end_done_d  = (rep_q == RW'(1));
    end_rep_d   = (rep_q != '0) ? rep_q - RW'(1) : rep_q;
    end_state_d = GAP;
    end_intr_d  = 1'b0;
    end_tmr_d   = gap_len - TW'(1);
    if (end_done_d) begin
      end_state_d = IDLE;
      end_tmr_d   = '0;
    end else if (gap_len == '0) begin
      end_state_d = ASSERT;
      end_intr_d  = 1'b1;
      end_tmr_d   = wid_ld;
    end
  end

  // Channel FSM with registered interrupt and done outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      rep_q   <= '0;
      intr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        intr_q  <= 1'b0;
      end else if (fin) begin
        state_q <= end_state_d;
        intr_q  <= end_intr_d;
        tmr_q   <= end_tmr_d;
        rep_q   <= end_rep_d;
        done_q  <= end_done_d;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q <= DELAY;
              tmr_q   <= TW'(dly);
              rep_q   <= cnt;
            end
          end
          DELAY, GAP: begin
            if (tmr_q == '0) begin
              state_q <= ASSERT;
              intr_q  <= 1'b1;
              tmr_q   <= wid_ld;
            end else begin
              tmr_q <= tmr_q - TW'(1);
            end
          end
          ASSERT: begin
            if (lvl) state_q <= WAIT_ACK;
            else tmr_q <= tmr_q - TW'(1);
          end
          WAIT_ACK: state_q <= WAIT_ACK;
          default: begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign intr_o = intr_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: rtl/intr_stim_gen.sv
// intr_stim_gen: multi-channel programmable interrupt stimulus.
// Define INTR_STIM_JITTER_EN to add LFSR jitter to gap lengths.
module intr_stim_gen
  import intr_stim_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CW        = 16,
  parameter int unsigned RW        = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  intr_stim_if.slave        cfg,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [NUM_CH-1:0] abort_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] intr_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] done_o
);

  ch_cfg_t           wr_cfg;
  ch_cfg_t           cfg_q   [NUM_CH];
  ch_cfg_t           eff_cfg [NUM_CH];
  logic [NUM_CH-1:0] wr_ok;
  logic              err_d;
  logic              err_q;
  logic [JW-1:0]     jit;

  // Widen the bus fields into the shared config record.
  always_comb begin
    wr_cfg      = '0;
    wr_cfg.mode = mode_e'(cfg.cfg_mode_i);
    wr_cfg.dly  = CW_MAX'(cfg.cfg_dly_i);
    wr_cfg.wid  = CW_MAX'(cfg.cfg_wid_i);
    wr_cfg.gap  = CW_MAX'(cfg.cfg_gap_i);
    wr_cfg.cnt  = RW_MAX'(cfg.cfg_cnt_i);
  end

  // Accept writes to idle or starting channels; the new
  // values bypass to the channel so a same-cycle start uses them.
  always_comb begin
    err_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ok[c]   = 1'b0;
      eff_cfg[c] = cfg_q[c];
      if (cfg.cfg_we_i && (int'(cfg.cfg_ch_i) == c)) begin
        if (!busy_o[c] || start_i[c]) begin
          wr_ok[c]   = 1'b1;
          eff_cfg[c] = wr_cfg;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Config registers and the reject pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NUM_CH; c++) cfg_q[c] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok[c]) cfg_q[c] <= wr_cfg;
      end
      err_q <= err_d;
    end
  end

  assign cfg.cfg_err_o = err_q;

`ifdef INTR_STIM_JITTER_EN
  logic [15:0] lfsr_q;

  // Free-running jitter source, restarted from the seed on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_next(lfsr_q);
  end

  assign jit = lfsr_q[JW-1:0];
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign jit = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    intr_stim_chan #(
      .CW (CW),
      .RW (RW)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cfg_i   (eff_cfg[c]),
      .jit_i   (jit),
      .start_i (start_i[c]),
      .abort_i (abort_i[c]),
      .ack_i   (ack_i[c]),
      .intr_o  (intr_o[c]),
      .busy_o  (busy_o[c]),
      .done_o  (done_o[c])
    );
  end

endmodule

// File: tb/tb_intr_stim_gen.sv
// tb_intr_stim_gen: directed scenarios plus randomized traffic
// against a time-stamp based reference model.
module tb_intr_stim_gen;

`ifdef INTR_STIM_JITTER_EN
  localparam int JIT_ON = 1;
`else
  localparam int JIT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start, abort, ack;
  logic [1:0] intr, busy, done;

  intr_stim_if #(.NUM_CH(2), .CW(16), .RW(8)) cfg_bus ();

  intr_stim_gen #(
    .NUM_CH    (2),
    .CW        (16),
    .RW        (8),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .cfg     (cfg_bus),
    .start_i (start),
    .abort_i (abort),
    .ack_i   (ack),
    .intr_o  (intr),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;

  // Reference model: absolute edge times of the next rise/fall.
  int          t = 0;
  bit          m_act [2];
  bit          m_high[2];
  bit          m_done[2];
  bit          m_err;
  int          m_rise[2];
  int          m_fall[2];
  int          m_n   [2];
  int          m_rep [2];
  int          m_mode[2];
  int          m_dly [2];
  int          m_wid [2];
  int          m_gap [2];
  int          m_cnt [2];
  logic [15:0] m_lfsr;

  function automatic void model_edge();
    int wp, gl, c;
    t++;
    m_err = 1'b0;
    for (int i = 0; i < 2; i++) m_done[i] = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_high[i] = 0;
        m_mode[i] = 0; m_dly[i] = 0; m_wid[i] = 0;
        m_gap[i] = 0; m_cnt[i] = 0;
      end
      m_lfsr = 16'hACE1;
      return;
    end
    if (cfg_bus.cfg_we_i) begin
      c = int'(cfg_bus.cfg_ch_i);
      if (!m_act[c] || start[c]) begin
        m_mode[c] = int'(cfg_bus.cfg_mode_i);
        m_dly[c]  = int'(cfg_bus.cfg_dly_i);
        m_wid[c]  = int'(cfg_bus.cfg_wid_i);
        m_gap[c]  = int'(cfg_bus.cfg_gap_i);
        m_cnt[c]  = int'(cfg_bus.cfg_cnt_i);
      end else begin
        m_err = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      wp = (m_wid[i] == 0) ? 1 : m_wid[i];
      if (abort[i]) begin
        m_act[i] = 0; m_high[i] = 0;
      end else if (!m_act[i]) begin
        if (start[i]) begin
          m_act[i] = 1; m_high[i] = 0; m_n[i] = 0;
          m_rise[i] = t + m_dly[i] + 1;
          m_rep[i] = m_cnt[i];
        end
      end else if (m_high[i]) begin
        if (m_mode[i] != 0 ? ack[i] : (t == m_fall[i])) begin
          m_n[i]++;
          if (m_rep[i] != 0 && m_n[i] == m_rep[i]) begin
            m_act[i] = 0; m_high[i] = 0; m_done[i] = 1;
          end else begin
            gl = m_gap[i] + JIT_ON * int'(m_lfsr[3:0]);
            if (gl == 0) m_fall[i] = t + wp;
            else begin m_high[i] = 0; m_rise[i] = t + gl; end
          end
        end
      end else if (t == m_rise[i]) begin
        m_high[i] = 1; m_fall[i] = t + wp;
      end
    end
    m_lfsr = {m_lfsr[14:0],
              m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    start = '0; abort = '0; ack = '0;
    cfg_bus.cfg_we_i = 0; cfg_bus.cfg_ch_i = 0;
    cfg_bus.cfg_mode_i = 0; cfg_bus.cfg_dly_i = 0;
    cfg_bus.cfg_wid_i = 0; cfg_bus.cfg_gap_i = 0;
    cfg_bus.cfg_cnt_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_cfg(input int ch, input int md, input int d,
                         input int w, input int g, input int n);
    cfg_bus.cfg_ch_i   = 1'(ch);
    cfg_bus.cfg_mode_i = 1'(md);
    cfg_bus.cfg_dly_i  = 16'(d);
    cfg_bus.cfg_wid_i  = 16'(w);
    cfg_bus.cfg_gap_i  = 16'(g);
    cfg_bus.cfg_cnt_i  = 8'(n);
  endtask

  task automatic cfg_write(input int ch, input int md, input int d,
                           input int w, input int g, input int n);
    set_cfg(ch, md, d, w, g, n);
    cfg_bus.cfg_we_i = 1'b1;
    tick();
    cfg_bus.cfg_we_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (intr !== 2'b00) begin errs++; $display("FAIL reset_intr got %b want 00", intr); end
    vec++; if (busy !== 2'b00) begin errs++; $display("FAIL reset_busy got %b want 00", busy); end
    vec++; if (done !== 2'b00) begin errs++; $display("FAIL reset_done got %b want 00", done); end
    vec++; if (cfg_bus.cfg_err_o !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", cfg_bus.cfg_err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_write(0, 0, 0, 10, 0, 1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tick(); tick();
    vec++; if (intr[0] !== 1'b1) begin errs++; $display("FAIL mid_pre_intr got %b want 1", intr[0]); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    vec++; if (intr[0] !== 1'b0) begin errs++; $display("FAIL mid_intr got %b want 0", intr[0]); end
    vec++; if (busy[0] !== 1'b0) begin errs++; $display("FAIL mid_busy got %b want 0", busy[0]); end
    tick();
    vec++; if (intr[0] !== 1'b0) begin errs++; $display("FAIL mid_after_intr got %b want 0", intr[0]); end
  endtask

  // dly=3 wid=2 gap=4 cnt=3; r counts edges after the start edge.
  task automatic test_pulse_seq(input bit inject_write);
    logic ei, eb, ed, ee;
    do_reset();
    cfg_write(0, 0, 3, 2, 4, 3);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int r = 1; r <= 22; r++) begin
      if (inject_write && r == 2) begin
        set_cfg(0, 1, 0, 7, 1, 9);
        cfg_bus.cfg_we_i = 1'b1;
      end else begin
        cfg_bus.cfg_we_i = 1'b0;
      end
      tick();
      ei = (r >= 4 && r <= 5) || (r >= 10 && r <= 11) ||
           (r >= 16 && r <= 17);
      eb = (r < 18);
      ed = (r == 18);
      ee = inject_write && (r == 2);
      vec++; if (intr[0] !== ei) begin errs++; $display("FAIL pulse_intr r=%0d got %b want %b", r, intr[0], ei); end
      vec++; if (busy[0] !== eb) begin errs++; $display("FAIL pulse_busy r=%0d got %b want %b", r, busy[0], eb); end
      vec++; if (done[0] !== ed) begin errs++; $display("FAIL pulse_done r=%0d got %b want %b", r, done[0], ed); end
      vec++; if (cfg_bus.cfg_err_o !== ee) begin errs++; $display("FAIL cfg_err r=%0d got %b want %b", r, cfg_bus.cfg_err_o, ee); end
    end
  endtask

  // ch1 LEVEL dly=0 cnt=1; ack is sampled at edge 8.
  task automatic test_level();
    logic ei, ed;
    do_reset();
    cfg_write(1, 1, 0, 0, 0, 1);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    for (int r = 1; r <= 11; r++) begin
      ack[1] = (r == 8);
      tick();
      ei = (r <= 7);
      ed = (r == 8);
      vec++; if (intr[1] !== ei) begin errs++; $display("FAIL level_intr r=%0d got %b want %b", r, intr[1], ei); end
      vec++; if (done[1] !== ed) begin errs++; $display("FAIL level_done r=%0d got %b want %b", r, done[1], ed); end
      vec++; if (intr[0] !== 1'b0) begin errs++; $display("FAIL level_ch0 r=%0d got %b want 0", r, intr[0]); end
    end
    ack[1] = 1'b0;
  endtask

  // cnt=0 wid=1 gap=0: steady high until abort sampled at edge 12.
  task automatic test_abort();
    logic ei;
    do_reset();
    cfg_write(0, 0, 0, 1, 0, 0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      abort[0] = (r == 12);
      tick();
      ei = (r < 12);
      vec++; if (intr[0] !== ei) begin errs++; $display("FAIL abort_intr r=%0d got %b want %b", r, intr[0], ei); end
      vec++; if (busy[0] !== ei) begin errs++; $display("FAIL abort_busy r=%0d got %b want %b", r, busy[0], ei); end
      vec++; if (done[0] !== 1'b0) begin errs++; $display("FAIL abort_done r=%0d got %b want 0", r, done[0]); end
    end
    abort[0] = 1'b0;
  endtask

  task automatic test_random();
    int ch;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(399) != 0);
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(7) == 0);
        abort[i] = ($urandom_range(79) == 0);
        ack[i]   = ($urandom_range(3) == 0);
      end
      ch = int'($urandom_range(1));
      set_cfg(ch, int'($urandom_range(1)), int'($urandom_range(5)),
              int'($urandom_range(4)), int'($urandom_range(4)),
              int'($urandom_range(3)));
      cfg_bus.cfg_we_i = ($urandom_range(5) == 0);
      if (cfg_bus.cfg_we_i && m_act[ch]) start[ch] = 1'b0;
      tick();
      vec++; if (intr !== {m_high[1], m_high[0]}) begin errs++; $display("FAIL rnd_intr k=%0d got %b want %b%b", k, intr, m_high[1], m_high[0]); end
      vec++; if (busy !== {m_act[1], m_act[0]}) begin errs++; $display("FAIL rnd_busy k=%0d got %b want %b%b", k, busy, m_act[1], m_act[0]); end
      vec++; if (done !== {m_done[1], m_done[0]}) begin errs++; $display("FAIL rnd_done k=%0d got %b want %b%b", k, done, m_done[1], m_done[0]); end
      vec++; if (cfg_bus.cfg_err_o !== m_err) begin errs++; $display("FAIL rnd_err k=%0d got %b want %b", k, cfg_bus.cfg_err_o, m_err); end
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

`ifdef INTR_STIM_JITTER_EN
  // gap=4 plus 0..15 jitter; two runs from reset must match.
  task automatic test_jitter();
    int rises [2][12];
    int n, low, r;
    logic prev;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      cfg_write(0, 0, 0, 1, 4, 0);
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      n = 0; low = 0; prev = 1'b0; r = 0;
      while (n < 12 && r < 600) begin
        tick(); r++;
        if (intr[0]) begin
          if (!prev && n > 0) begin
            vec++; if (low < 4 || low > 19) begin errs++; $display("FAIL jit_gap run=%0d got %0d want 4..19", p, low); end
          end
          if (!prev) begin rises[p][n] = r; n++; end
          low = 0;
        end else begin
          low++;
        end
        prev = intr[0];
      end
      vec++; if (n < 12) begin errs++; $display("FAIL jit_timeout run=%0d got %0d pulses want 12", p, n); end
    end
    for (int i = 0; i < 12; i++) begin
      vec++; if (rises[1][i] !== rises[0][i]) begin errs++; $display("FAIL jit_repeat i=%0d got %0d want %0d", i, rises[1][i], rises[0][i]); end
    end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_lfsr = 16'hACE1;
    test_reset();
    test_reset_mid();
`ifndef INTR_STIM_JITTER_EN
    test_pulse_seq(1'b0);
    test_pulse_seq(1'b1);
    test_abort();
`else
    test_jitter();
`endif
    test_level();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
